// File: rtl/rgb_led_pkg.sv
// Shared definitions for the RGB status LED decoder.
// Holds the 2-bit status code constants, the LED FSM state type and a
// helper that maps a committed code onto its FSM state.
package rgb_led_pkg;

    localparam logic [1:0] CODE_IDLE  = 2'b00;
    localparam logic [1:0] CODE_OK    = 2'b01;
    localparam logic [1:0] CODE_WARN  = 2'b10;
    localparam logic [1:0] CODE_FAULT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OK    = 2'b01,
        S_WARN  = 2'b10,
        S_FAULT = 2'b11
    } led_state_t;

    function automatic led_state_t code_to_state(input logic [1:0] code);
        led_state_t st;
        case (code)
            CODE_OK:    st = S_OK;
            CODE_WARN:  st = S_WARN;
            CODE_FAULT: st = S_FAULT;
            default:    st = S_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rgb_led_status_decoder_filter.sv
// code_stability_filter: synchronises an asynchronous multi-bit code and
// only accepts a new value once it has been seen unchanged for
// STABLE_CYCLES consecutive synchronised samples.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   code_in       raw code, asynchronous to clk
//   commit        combinational: the committed code updates on this edge
//   commit_code   value being committed when commit is high
//   code_changed  registered one-cycle pulse after each commit
//   settled       committed code equals the synchronised input
module code_stability_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int WIDTH         = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] code_in,
    output logic             commit,
    output logic [WIDTH-1:0] commit_code,
    output logic             code_changed,
    output logic             settled
);

    localparam logic [CNT_W-1:0] SCNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] committed_q, committed_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             code_changed_q, code_changed_d;

    always_comb begin
        sync1_d        = code_in;
        sync2_d        = sync1_q;
        cand_d         = cand_q;
        scnt_d         = scnt_q;
        committed_d    = committed_q;
        code_changed_d = 1'b0;
        commit         = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            scnt_d = '0;
        end else if (scnt_q == SCNT_LAST) begin
            // Count saturates here; a glitch that returned to the committed
            // value lands in this branch with cand == committed: no pulse.
            if (cand_q != committed_q) begin
                committed_d    = cand_q;
                code_changed_d = 1'b1;
                commit         = 1'b1;
            end
        end else begin
            scnt_d = scnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            cand_q         <= '0;
            committed_q    <= '0;
            scnt_q         <= '0;
            code_changed_q <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            committed_q    <= committed_d;
            scnt_q         <= scnt_d;
            code_changed_q <= code_changed_d;
        end
    end

    assign commit_code  = cand_q;
    assign code_changed = code_changed_q;
    assign settled      = (sync2_q == committed_q);

endmodule

// File: rtl/rgb_led_status_decoder.sv
// rgb_led_status_decoder: turns the 2-bit status code from the selector
// logic into steady or blinking patterns on the board R/G/B LED pins.
//
// State table:
//   S_IDLE  | code 00, blue steady
//   S_OK    | code 01, green steady
//   S_WARN  | code 10, red slow blink (BLINK_DIV cycles per half-period)
//   S_FAULT | code 11, red+green fast blink (BLINK_DIV/2 per half-period)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   code_in[1:0]         status code, asynchronous to clk
//   en                   LED enable, 0 forces all LEDs off
//   led_r, led_g, led_b  registered LED drives
//   code_changed         one-cycle pulse when a new code is committed
//   settled              committed code equals synchronised input
//
// Build option: define RGB_LED_ACTIVE_LOW_EN for common-anode LEDs
// (LED pins reset to 1, off = 1, lit = 0).
module rgb_led_status_decoder
    import rgb_led_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_DIV     = 8,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] code_in,
    input  logic       en,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       code_changed,
    output logic       settled
);

`ifdef RGB_LED_ACTIVE_LOW_EN
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;
`else
    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;
`endif

    localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] PCNT_HALF = CNT_W'(BLINK_DIV / 2 - 1);

    logic       commit;
    logic [1:0] commit_code;

    code_stability_filter #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .WIDTH        (2),
        .CNT_W        (CNT_W)
    ) u_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_in     (code_in),
        .commit      (commit),
        .commit_code (commit_code),
        .code_changed(code_changed),
        .settled     (settled)
    );

    led_state_t       state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             slow_q, slow_d;
    logic             fast_q, fast_d;
    logic             en_prev_q, en_prev_d;
    logic             led_r_q, led_r_d;
    logic             led_g_q, led_g_d;
    logic             led_b_q, led_b_d;
    logic             restart;
    logic             lit_r, lit_g, lit_b;

    // State moves on the commit edge itself so the LEDs follow one edge later.
    always_comb begin
        state_d = state_q;
        if (commit) begin
            state_d = code_to_state(commit_code);
        end
    end

    // Restarting the prescaler on commit or enable makes blinking states
    // always begin with a full lit half-period. Restart beats wrap.
    always_comb begin
        en_prev_d = en;
        restart   = commit | (en & ~en_prev_q);
        pcnt_d    = pcnt_q;
        slow_d    = slow_q;
        fast_d    = fast_q;
        if (restart) begin
            pcnt_d = '0;
            slow_d = 1'b1;
            fast_d = 1'b1;
        end else if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
            slow_d = ~slow_q;
            fast_d = ~fast_q;
        end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            if (pcnt_q == PCNT_HALF) begin
                fast_d = ~fast_q;
            end
        end
    end

    always_comb begin
        lit_r = 1'b0;
        lit_g = 1'b0;
        lit_b = 1'b0;
        case (state_q)
            S_IDLE:  lit_b = 1'b1;
            S_OK:    lit_g = 1'b1;
            S_WARN:  lit_r = slow_q;
            S_FAULT: begin
                lit_r = fast_q;
                lit_g = fast_q;
            end
            default: lit_b = 1'b1;
        endcase
        led_r_d = (en & lit_r) ? LED_ON : LED_OFF;
        led_g_d = (en & lit_g) ? LED_ON : LED_OFF;
        led_b_d = (en & lit_b) ? LED_ON : LED_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            slow_q    <= 1'b1;
            fast_q    <= 1'b1;
            en_prev_q <= 1'b0;
            led_r_q   <= LED_OFF;
            led_g_q   <= LED_OFF;
            led_b_q   <= LED_OFF;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            slow_q    <= slow_d;
            fast_q    <= fast_d;
            en_prev_q <= en_prev_d;
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            led_b_q   <= led_b_d;
        end
    end

    assign led_r = led_r_q;
    assign led_g = led_g_q;
    assign led_b = led_b_q;

endmodule
